imem_boot_loader: RTL and testbench

- Byte-stream boot loader that sits directly upstream of the single-cycle CPU's instruction memory.
- Receives a framed program image over a valid/ready byte interface, assembles big-endian 32-bit words and writes them through the imem write port.
- Verifies an XOR checksum over the image.
- Holds the CPU in reset until a good image is loaded; a failed load keeps it held and reports an error code.

---
 rtl/imem_boot_loader_if.sv | 30 +++
 rtl/imem_boot_loader.sv | 165 ++++++++++++++++
 tb/tb_imem_boot_loader.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_boot_loader_if.sv
// Byte-stream receive and imem write bundle for the boot loader.
// master: stream source / imem side; slave: the loader itself.
interface imem_boot_loader_if #(
   parameter int ADDR_WIDTH = 8
);
   logic [7:0]            rx_data;
   logic                  rx_valid;
   logic                  rx_ready;
   logic                  imem_we;
   logic [ADDR_WIDTH-1:0] imem_waddr;
   logic [31:0]           imem_wdata;

   modport master (
      output rx_data,
      output rx_valid,
      input  rx_ready,
      input  imem_we,
      input  imem_waddr,
      input  imem_wdata
   );

   modport slave (
      input  rx_data,
      input  rx_valid,
      output rx_ready,
      output imem_we,
      output imem_waddr,
      output imem_wdata
   );
endinterface

// File: rtl/imem_boot_loader.sv
// Boot loader: framed byte image -> big-endian imem words, XOR checked.
// Ports: clk, reset (async, active-low), start, bus (rx stream in, imem
// write out), cpu_reset, busy, done, error, error_code, words_loaded.
module imem_boot_loader #(
   parameter int ADDR_WIDTH     = 8,
   parameter int TIMEOUT_CYCLES = 1000
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   imem_boot_loader_if.slave     bus,
   output logic                  cpu_reset,
   output logic                  busy,
   output logic                  done,
   output logic                  error,
   output logic [1:0]            error_code,
   output logic [ADDR_WIDTH:0]   words_loaded
);

   localparam int TW = $clog2(TIMEOUT_CYCLES);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN_HI,
      S_LEN_LO,
      S_DATA,
      S_CHECK,
      S_DONE,
      S_ERROR
   } state_t;

   state_t              r_state;
   logic [15:0]         r_len;
   logic [23:0]         r_asm;
   logic [1:0]          r_bcnt;
   logic [7:0]          r_csum;
   logic [TW-1:0]       r_tmo;

   logic                w_acc;
   logic [15:0]         w_len;
   logic                w_len_bad;
   logic [ADDR_WIDTH:0] w_wnext;
   logic                w_last;
   logic                w_tmo_exp;

   // rx_ready is high exactly in the receiving states, so it doubles
   // as the "receiving" state flag.
   assign w_acc     = bus.rx_valid & bus.rx_ready;
   assign w_len     = {r_len[15:8], bus.rx_data};
   assign w_len_bad = (w_len == 16'd0) ||
                      (32'(w_len) > (32'd1 << ADDR_WIDTH));
   assign w_wnext   = words_loaded + {{ADDR_WIDTH{1'b0}}, 1'b1};
   assign w_last    = (32'(w_wnext) == 32'(r_len));
   assign w_tmo_exp = (r_tmo == TW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state         <= S_IDLE;
         r_len           <= '0;
         r_asm           <= '0;
         r_bcnt          <= '0;
         r_csum          <= '0;
         r_tmo           <= '0;
         bus.rx_ready    <= 1'b0;
         bus.imem_we     <= 1'b0;
         bus.imem_waddr  <= '0;
         bus.imem_wdata  <= '0;
         cpu_reset       <= 1'b1;
         busy            <= 1'b0;
         done            <= 1'b0;
         error           <= 1'b0;
         error_code      <= 2'd0;
         words_loaded    <= '0;
      end else begin
         bus.imem_we <= 1'b0;
         unique case (r_state)
            S_IDLE, S_DONE, S_ERROR: begin
               if (start) begin
                  r_state      <= S_LEN_HI;
                  r_csum       <= '0;
                  r_bcnt       <= '0;
                  r_tmo        <= '0;
                  bus.rx_ready <= 1'b1;
                  cpu_reset    <= 1'b1;
                  busy         <= 1'b1;
                  done         <= 1'b0;
                  error        <= 1'b0;
                  error_code   <= 2'd0;
                  words_loaded <= '0;
               end
            end
            S_LEN_HI: begin
               if (w_acc) begin
                  r_len[15:8] <= bus.rx_data;
                  r_state     <= S_LEN_LO;
               end
            end
            S_LEN_LO: begin
               if (w_acc) begin
                  r_len[7:0] <= bus.rx_data;
                  if (w_len_bad) begin
                     r_state      <= S_ERROR;
                     bus.rx_ready <= 1'b0;
                     busy         <= 1'b0;
                     error        <= 1'b1;
                     error_code   <= 2'd1;
                  end else begin
                     r_state <= S_DATA;
                  end
               end
            end
            S_DATA: begin
               if (w_acc) begin
                  r_asm  <= {r_asm[15:0], bus.rx_data};
                  r_csum <= r_csum ^ bus.rx_data;
                  r_bcnt <= r_bcnt + 2'd1;
                  if (r_bcnt == 2'd3) begin
                     bus.imem_we    <= 1'b1;
                     bus.imem_wdata <= {r_asm, bus.rx_data};
                     bus.imem_waddr <= words_loaded[ADDR_WIDTH-1:0];
                     words_loaded   <= w_wnext;
                     if (w_last) begin
                        r_state <= S_CHECK;
                     end
                  end
               end
            end
            S_CHECK: begin
               if (w_acc) begin
                  bus.rx_ready <= 1'b0;
                  busy         <= 1'b0;
                  if (bus.rx_data == r_csum) begin
                     r_state   <= S_DONE;
                     done      <= 1'b1;
                     cpu_reset <= 1'b0;
                  end else begin
                     r_state    <= S_ERROR;
                     error      <= 1'b1;
                     error_code <= 2'd2;
                  end
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase

         // Idle-gap watchdog; an accept on the expiring cycle wins.
         if (bus.rx_ready) begin
            if (w_acc) begin
               r_tmo <= '0;
            end else if (w_tmo_exp) begin
               r_state      <= S_ERROR;
               bus.rx_ready <= 1'b0;
               busy         <= 1'b0;
               error        <= 1'b1;
               error_code   <= 2'd3;
            end else begin
               r_tmo <= r_tmo + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Scoreboard bench for imem_boot_loader: directed frames, expected
// writes/status queued by the driver and checked by a monitor.
module tb_imem_boot_loader;

   localparam int AW = 8;
   localparam int T  = 20;

   typedef struct packed {
      logic [7:0]  a;
      logic [31:0] d;
      logic [8:0]  w;
   } wr_t;

   typedef struct packed {
      logic       dn;
      logic       er;
      logic [1:0] code;
      logic [8:0] w;
      int         dly;
   } st_t;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          start = 1'b0;
   logic          cpu_reset, busy, done, error;
   logic [1:0]    error_code;
   logic [AW:0]   words_loaded;

   int            n_chk = 0;
   int            n_pass = 0;
   int            cyc = 0;
   int            acc_cyc = 0;
   logic          prev_fin = 1'b0;
   wr_t           exp_wr[$];
   st_t           exp_st[$];
   logic [31:0]   img[$];

   imem_boot_loader_if #(.ADDR_WIDTH(AW)) bus ();

   imem_boot_loader #(
      .ADDR_WIDTH    (AW),
      .TIMEOUT_CYCLES(T)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .bus         (bus),
      .cpu_reset   (cpu_reset),
      .busy        (busy),
      .done        (done),
      .error       (error),
      .error_code  (error_code),
      .words_loaded(words_loaded)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, want %0h", nm, act, exp);
   endtask

   task automatic fail(input string nm);
      n_chk++;
      $display("FAIL %s: got unexpected event, want none", nm);
   endtask

   // Monitor: pops expectations when the DUT writes or finishes.
   always @(negedge clk) begin
      wr_t  e;
      st_t  s;
      logic fin;
      if (reset && bus.imem_we) begin
         if (exp_wr.size() == 0) fail("we_unexp");
         else begin
            e = exp_wr.pop_front();
            chk("waddr", bus.imem_waddr, e.a);
            chk("wdata", bus.imem_wdata, e.d);
            chk("wcount", words_loaded, e.w);
            chk("wlat", cyc, acc_cyc);
            chk("wready", bus.rx_ready, 1);
         end
      end
      fin = done | error;
      if (reset && fin && !prev_fin) begin
         if (exp_st.size() == 0) fail("st_unexp");
         else begin
            s = exp_st.pop_front();
            chk("st_done", done, s.dn);
            chk("st_err", error, s.er);
            chk("st_code", error_code, s.code);
            chk("st_words", words_loaded, s.w);
            chk("st_cpurst", cpu_reset, !s.dn);
            chk("st_busy", busy, 0);
            chk("st_rdy", bus.rx_ready, 0);
            chk("st_lat", cyc, acc_cyc + s.dly);
         end
      end
      prev_fin = fin;
   end

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      int k;
      bus.rx_data  = b;
      bus.rx_valid = 1'b1;
      k = 0;
      @(negedge clk);
      while (!bus.rx_ready && k < 64) begin
         @(negedge clk);
         k++;
      end
      if (!bus.rx_ready) fail("rdy_wait");
      @(posedge clk);
      #1;
      acc_cyc = cyc;
   endtask

   task automatic drain(input int lim);
      int k;
      k = 0;
      while ((exp_wr.size() + exp_st.size()) > 0 && k < lim) begin
         @(posedge clk);
         k++;
      end
      #1;
      chk("drain", exp_wr.size() + exp_st.size(), 0);
      exp_wr.delete();
      exp_st.delete();
   endtask

   task automatic do_start();
      bus.rx_valid = 1'b0;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      chk("start_state",
          {busy, cpu_reset, done, error, error_code, words_loaded,
           bus.rx_ready},
          {1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 9'd0, 1'b1});
   endtask

   task automatic chk_rst(input string nm);
      chk(nm, {cpu_reset, bus.rx_ready, bus.imem_we, bus.imem_waddr,
               bus.imem_wdata, busy, done, error, error_code,
               words_loaded},
          {1'b1, 1'b0, 1'b0, 8'd0, 32'd0, 1'b0, 1'b0, 1'b0, 2'd0,
           9'd0});
   endtask

   task automatic frame(input int n, input logic [7:0] ck, input bit ok,
                        input int gap, input bit poke);
      logic [15:0] nl;
      logic [31:0] wd;
      nl = 16'(n);
      for (int i = 0; i < n; i++)
         exp_wr.push_back('{a: 8'(i), d: img[i], w: 9'(i + 1)});
      exp_st.push_back('{dn: ok, er: !ok, code: ok ? 2'd0 : 2'd2,
                         w: 9'(n), dly: 0});
      send_byte(nl[15:8]);
      send_byte(nl[7:0]);
      for (int i = 0; i < n; i++) begin
         wd = img[i];
         for (int j = 0; j < 4; j++) begin
            if (poke && j == 1) start = 1'b1;
            send_byte(wd[31-8*j -: 8]);
            start = 1'b0;
            if (gap > 0) begin
               bus.rx_valid = 1'b0;
               idle(gap);
            end
         end
      end
      send_byte(ck);
      bus.rx_valid = 1'b0;
      drain(64);
   endtask

   initial begin
      logic [7:0]  ck;
      logic [31:0] v;
      bus.rx_data  = 8'h00;
      bus.rx_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk_rst("rst_init");
      reset = 1'b1;
      idle(2);

      // Good 2-word frame, one idle cycle between bytes.
      img = {32'h2401_0005, 32'h0800_0000};
      do_start();
      frame(2, 8'h28, 1'b1, 1, 1'b0);

      // Same frame, bad checksum; restart from DONE.
      do_start();
      frame(2, 8'h2D, 1'b0, 0, 1'b0);

      // Zero length, restart from ERROR.
      do_start();
      exp_st.push_back('{dn: 0, er: 1, code: 2'd1, w: 9'd0, dly: 0});
      send_byte(8'h00);
      send_byte(8'h00);
      bus.rx_valid = 1'b0;
      drain(16);

      // Length 257 exceeds 256-word capacity.
      do_start();
      exp_st.push_back('{dn: 0, er: 1, code: 2'd1, w: 9'd0, dly: 0});
      send_byte(8'h01);
      send_byte(8'h01);
      bus.rx_valid = 1'b0;
      drain(16);

      // Stall T cycles after the 3rd data byte: timeout.
      do_start();
      exp_st.push_back('{dn: 0, er: 1, code: 2'd3, w: 9'd0, dly: T});
      send_byte(8'h00);
      send_byte(8'h01);
      send_byte(8'h24);
      send_byte(8'h01);
      send_byte(8'h00);
      bus.rx_valid = 1'b0;
      drain(T + 20);

      // Stall T-1 cycles: accept wins, load completes.
      do_start();
      exp_wr.push_back('{a: 8'd0, d: 32'h2401_0005, w: 9'd1});
      exp_st.push_back('{dn: 1, er: 0, code: 2'd0, w: 9'd1, dly: 0});
      send_byte(8'h00);
      send_byte(8'h01);
      send_byte(8'h24);
      send_byte(8'h01);
      send_byte(8'h00);
      bus.rx_valid = 1'b0;
      idle(T - 1);
      send_byte(8'h05);
      send_byte(8'h20);
      bus.rx_valid = 1'b0;
      drain(16);

      // Back-to-back 3 words with start pokes mid-load.
      img = {32'h1122_3344, 32'hA5A5_5A5A, 32'hDEAD_BEEF};
      do_start();
      frame(3, 8'h66, 1'b1, 0, 1'b1);

      // Reset mid-DATA, then a fresh load from address 0.
      do_start();
      send_byte(8'h00);
      send_byte(8'h04);
      send_byte(8'h13);
      send_byte(8'h57);
      #2;
      reset = 1'b0;
      #1;
      chk_rst("rst_async");
      bus.rx_valid = 1'b0;
      @(posedge clk);
      #1;
      chk_rst("rst_hold");
      reset = 1'b1;
      idle(1);
      img = {32'hCAFE_F00D};
      do_start();
      frame(1, 8'hC9, 1'b1, 0, 1'b0);

      // Full capacity: last address all-ones, words_loaded = 256.
      img = {};
      ck  = 8'h00;
      for (int i = 0; i < 256; i++) begin
         v = {8'(i), ~8'(i), 8'(i) ^ 8'h5A, 8'h3C};
         img.push_back(v);
         ck = ck ^ v[31:24] ^ v[23:16] ^ v[15:8] ^ v[7:0];
      end
      do_start();
      frame(256, ck, 1'b1, 0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
